nibble_add_seq: RTL and testbench
=================================

// Module: nibble_add_seq
// PURPOSE
//  Sequencer that drives one shared external 4-bit full adder (fa4 type: s, co, a, b, ci).
//  Performs wide additions nibble-serially, LSB nibble first, chaining carry between cycles.
//  Operands enter through a valid/ready input channel; results leave through a valid/ready output channel.
//  Sits between the operand source and the 4-bit adder instance; the adder itself stays combinational.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (W = 4*NIBBLES); legal range 1..16
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    operand request valid
//  in_ready   out  1    block can accept operands
//  in_a       in   W    operand A
//  in_b       in   W    operand B
//  in_ci      in   1    carry-in for the LSB nibble
//  out_valid  out  1    result valid
//  out_ready  in   1    result consumer ready
//  out_sum    out  W    result sum
//  out_co     out  1    carry-out of the MSB nibble
//  add_a      out  4    to adder a
//  add_b      out  4    to adder b
//  add_ci     out  1    to adder ci
//  add_s      in   4    from adder s
//  add_co     in   1    from adder co
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Reset: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_co=0, nibble counter=0.
//  - IDLE: in_ready=1. On in_valid&in_ready: register a, b, ci; counter<=0; carry_reg<=in_ci; go to RUN.
//  - RUN: in_ready=0. add_a=a_reg[4*cnt+:4], add_b=b_reg[4*cnt+:4], add_ci=carry_reg.
//    Each edge: sum_reg[4*cnt+:4]<=add_s; carry_reg<=add_co; cnt<=cnt+1.
//    When cnt==NIBBLES-1, the same edge goes to DONE.
//  - DONE: out_valid=1, out_sum=sum_reg, out_co=carry_reg, in_ready=0. On out_ready: go to IDLE; out_valid drops the next cycle.
//  - The adder is combinational: add_s/add_co are sampled in the same cycle that add_a/add_b/add_ci are driven.
//  - add_a/add_b/add_ci = 0 in IDLE and DONE.
//  - Latency: accept edge T -> out_valid high from edge T+NIBBLES. Throughput: one operation per NIBBLES+2 cycles at best.
//  - No overlap: in_ready=0 throughout RUN and DONE. in_valid is ignored there and inputs are not captured.
//  - out_sum/out_co are held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
//  - NIBBLES=1: exactly one RUN cycle, then DONE.
//  - Counter width is clog2(NIBBLES)+1 bits. The counter never wraps; it is cleared on accept.
//  - rst in any state: the next cycle is IDLE with reset values. A partial result is discarded and never presented.
//  - rst together with in_valid: reset wins and the operand is not captured.
// CONFIGURATION
//  SEQ_SUB_EN defined:
//   - Adds port in_sub (in, 1), captured alongside the operands.
//   - in_sub=1: b_reg<=~in_b and carry_reg<=1 (in_ci ignored); out_sum=A-B mod 2^W; out_co=1 means no borrow.
//   - in_sub=0: plain add.
//  SEQ_SUB_EN undefined:
//   - in_sub port is absent; add only.
// TESTING  (NIBBLES=4 unless noted)
//  1. a=0x1234, b=0x4321, ci=0 -> out_sum=0x5555, co=0; out_valid rises exactly 4 edges after accept.
//  2. a=0xFFFF, b=0x0001, ci=0 -> out_sum=0x0000, co=1 (carry ripples through all 4 nibble cycles).
//  3. a=0xFFFF, b=0xFFFF, ci=1 -> out_sum=0xFFFF, co=1.
//     Then hold out_ready=0 for 10 cycles -> out_valid, sum and co stay stable; in_ready=0; a new in_valid is ignored.
//  4. rst pulsed while in RUN with cnt=2 -> next cycle state=IDLE, in_ready=1, out_valid=0; the following op 0x0001+0x0001 -> 0x0002.
//  5. SEQ_SUB_EN: a=0x0005, b=0x0007, in_sub=1 -> out_sum=0xFFFE, co=0; a=0x0007, b=0x0005 -> 0x0002, co=1.
//  6. NIBBLES=1: a=0xF, b=0x1, ci=1 -> sum=0x1, co=1 one edge after accept; 200 random ops match (a+b+ci) reference.

Source files
------------

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: nibble-serial wide adder driving an external 4-bit adder; SEQ_SUB_EN adds in_sub (A-B)
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_ci,
`ifdef SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_co,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_ci,
  input  logic [3:0]             add_s,
  input  logic                   add_co
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_reg, b_reg, sum_reg;
  logic [CW-1:0] cnt;
  logic          carry, sub;
`ifdef SEQ_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif
  assign out_sum = sum_reg;
  assign out_co  = carry;
  assign add_ci  = (state == RUN) ? carry : 1'b0;
  always_comb begin
    add_a = 4'd0;
    add_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++)
      if (state == RUN && cnt == CW'(i)) begin
        add_a = a_reg[4*i +: 4];
        add_b = b_reg[4*i +: 4];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_reg    <= in_a;
          b_reg    <= sub ? ~in_b : in_b;
          carry    <= sub ? 1'b1 : in_ci;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (cnt == CW'(i)) sum_reg[4*i +: 4] <= add_s;
          carry <= add_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIBBLES - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed checks of nibble_add_seq at NIBBLES=4 and NIBBLES=1 with a behavioural 4-bit adder
module tb_nibble_add_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, in_valid = 1'b0, in_ci = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_sum;
  logic        in_ready, out_valid, out_co, add_ci, add_co;
  logic [3:0]  add_a, add_b, add_s;
  logic        iv1 = 1'b0, ci1 = 1'b0, or1 = 1'b0, sub1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, s1, aa1, ab1, as1;
  logic        ir1, ov1, co1, aci1, aco1;
  int errors = 0, checks = 0, n;
  logic [4:0] exp1;
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};
  assign {aco1, as1}     = {1'b0, aa1} + {1'b0, ab1} + {4'd0, aci1};
  nibble_add_seq #(.NIBBLES(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
`ifdef SEQ_SUB_EN
    .in_sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co));
  nibble_add_seq #(.NIBBLES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .in_ci(ci1),
`ifdef SEQ_SUB_EN
    .in_sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_co(co1),
    .add_a(aa1), .add_b(ab1), .add_ci(aci1), .add_s(as1), .add_co(aco1));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  task automatic go4(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
    in_a = a; in_b = b; in_ci = ci; sub = s; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1 n++;
    end
    chk("latency4", n, 4);
  endtask
  task automatic rel4;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
  endtask
  task automatic go1(input logic [3:0] a, input logic [3:0] b, input logic ci);
    a1 = a; b1 = b; ci1 = ci; iv1 = 1'b1;
    @(posedge clk); #1 iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 10) begin
      @(posedge clk); #1 n++;
    end
    exp1 = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    chk("latency1", n, 1);
    chk("sum1", {28'd0, s1}, {28'd0, exp1[3:0]});
    chk("co1", {31'd0, co1}, {31'd0, exp1[4]});
    or1 = 1'b1;
    @(posedge clk); #1 or1 = 1'b0;
  endtask
  initial begin
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_co", {31'd0, out_co}, 32'd0);
    chk("rst_add_a", {28'd0, add_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    go4(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("t1_sum", {16'd0, out_sum}, 32'h5555);
    chk("t1_co", {31'd0, out_co}, 32'd0);
    chk("t1_add_idle", {27'd0, add_a, add_ci}, 32'd0);
    rel4();
    go4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t2_sum", {16'd0, out_sum}, 32'h0000);
    chk("t2_co", {31'd0, out_co}, 32'd1);
    rel4();
    go4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    chk("t3_sum", {16'd0, out_sum}, 32'hFFFF);
    chk("t3_co", {31'd0, out_co}, 32'd1);
    in_a = 16'h0000; in_b = 16'h0000; in_ci = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {16'd0, out_sum}, 32'hFFFF);
      chk("hold_co", {31'd0, out_co}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    rel4();
    @(posedge clk); #1;
    chk("no_capture", {31'd0, out_valid}, 32'd0);
    in_a = 16'hABCD; in_b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t4_running", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_sum", {16'd0, out_sum}, 32'd0);
    repeat (6) @(posedge clk);
    #1 chk("t4_no_partial", {31'd0, out_valid}, 32'd0);
    go4(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("t4_sum2", {16'd0, out_sum}, 32'h0002);
    chk("t4_co2", {31'd0, out_co}, 32'd0);
    rel4();
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h7777;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wins_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wins_valid", {31'd0, out_valid}, 32'd0);
`ifdef SEQ_SUB_EN
    go4(16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("t5_sum_a", {16'd0, out_sum}, 32'hFFFE);
    chk("t5_co_a", {31'd0, out_co}, 32'd0);
    rel4();
    go4(16'h0007, 16'h0005, 1'b1, 1'b1);
    chk("t5_sum_b", {16'd0, out_sum}, 32'h0002);
    chk("t5_co_b", {31'd0, out_co}, 32'd1);
    rel4();
    go4(16'h0007, 16'h0005, 1'b0, 1'b0);
    chk("t5_add", {16'd0, out_sum}, 32'h000C);
    rel4();
`endif
    go1(4'hF, 4'h1, 1'b1);
    for (int i = 0; i < 200; i++)
      go1(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
